cat_rec_ctrl: RTL and testbench

CAT_REC_CTRL -- requirements
Module: cat_rec_ctrl

---
 rtl/cat_rec_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cat_rec_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cat_rec_ctrl.sv
// APB-controlled image streamer: fetches NUM_WORDS words from a register file
// to the datapath and latches the result. Optional watchdog: CTRL_TIMEOUT_EN.
module cat_rec_ctrl #(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_DEPTH = 12,
  parameter int NUM_WORDS       = 4096,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_DEPTH:0]   PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       rf_we,
  output logic [AMBA_ADDR_DEPTH-1:0] rf_waddr,
  output logic [AMBA_WORD-1:0]       rf_wdata,
  output logic                       rf_re,
  output logic [AMBA_ADDR_DEPTH-1:0] rf_raddr,
  input  logic [AMBA_WORD-1:0]       rf_rdata,
  output logic                       dp_valid,
  output logic [AMBA_WORD-1:0]       dp_data,
  output logic                       dp_last,
  input  logic                       dp_ready,
  input  logic                       dp_res_valid,
  input  logic                       dp_res,
  output logic                       busy,
  output logic                       CatRecognized,
  output logic                       done
);

  localparam int AW1 = AMBA_ADDR_DEPTH + 1;
  localparam logic [AW1-1:0] LAST = AW1'(NUM_WORDS);

  typedef enum logic [2:0] {
    IDLE, FETCH, STREAM, WAIT_RES, DONE
  } state_t;

  state_t                     r_state;
  logic [AW1-1:0]             r_cnt;
  logic [AMBA_WORD-1:0]       r_prdata;
  logic                       r_rf_we;
  logic [AMBA_ADDR_DEPTH-1:0] r_rf_waddr;
  logic [AMBA_WORD-1:0]       r_rf_wdata;
  logic                       r_rf_re;
  logic                       r_dp_valid;
  logic [AMBA_WORD-1:0]       r_dp_data;
  logic                       r_dp_last;
  logic                       r_cat;
  logic                       r_done;
  logic                       r_wr_err;

  logic       w_wr;
  logic       w_rd;
  logic       w_ctrl;
  logic       w_busy;
  logic       w_start;
  logic       w_abort;
  logic       w_addr_err;
  logic       w_timeout;
  logic [4:0] w_status;

  assign w_wr    = PSEL & PENABLE & PWRITE;
  assign w_rd    = PSEL & PENABLE & ~PWRITE;
  assign w_ctrl  = (PADDR == '0);
  assign w_busy  = (r_state == FETCH) || (r_state == STREAM) ||
                   (r_state == WAIT_RES);
  // DONE is leaving for IDLE this cycle, so a start there is accepted
  assign w_start = w_wr & w_ctrl & PWDATA[0] &
                   ((r_state == IDLE) || (r_state == DONE));
  assign w_abort = w_wr & w_ctrl & ~PWDATA[0] & (r_state != IDLE);
  assign w_addr_err = w_busy || (PADDR > LAST);
  assign w_status = {w_timeout, r_wr_err, r_cat, r_done, w_busy};

`ifdef CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wcnt;
  logic          r_timeout;
  assign w_timeout = r_timeout;
`else
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_prdata   <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_rf_re    <= 1'b0;
      r_dp_valid <= 1'b0;
      r_dp_data  <= '0;
      r_dp_last  <= 1'b0;
      r_cat      <= 1'b0;
      r_done     <= 1'b0;
      r_wr_err   <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
      r_wcnt     <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_rf_we <= 1'b0;
      r_rf_re <= 1'b0;
      if (w_rd)
        r_prdata <= w_ctrl ? {{(AMBA_WORD-5){1'b0}}, w_status} : '0;
      if (w_wr && !w_ctrl) begin
        if (w_addr_err) begin
          r_wr_err <= 1'b1;
        end else begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= PADDR[AMBA_ADDR_DEPTH-1:0];
          r_rf_wdata <= PWDATA;
        end
      end
      if (w_abort) begin
        r_state    <= IDLE;
        r_done     <= 1'b0;
        r_dp_valid <= 1'b0;
        r_dp_last  <= 1'b0;
      end else if (w_start) begin
        r_state  <= FETCH;
        r_cnt    <= AW1'(1);
        r_done   <= 1'b0;
        r_cat    <= 1'b0;
        r_wr_err <= 1'b0;
        r_rf_re  <= 1'b1;
`ifdef CTRL_TIMEOUT_EN
        r_timeout <= 1'b0;
`endif
      end else begin
        unique case (r_state)
          FETCH: r_state <= STREAM;
          STREAM: begin
            // first STREAM cycle captures the 1-cycle-latency read data
            if (!r_dp_valid) begin
              r_dp_valid <= 1'b1;
              r_dp_data  <= rf_rdata;
              r_dp_last  <= (r_cnt == LAST);
            end else if (dp_ready) begin
              r_dp_valid <= 1'b0;
              r_dp_last  <= 1'b0;
              if (r_cnt == LAST) begin
                r_state <= WAIT_RES;
`ifdef CTRL_TIMEOUT_EN
                r_wcnt  <= '0;
`endif
              end else begin
                r_cnt   <= r_cnt + AW1'(1);
                r_state <= FETCH;
                r_rf_re <= 1'b1;
              end
            end
          end
          WAIT_RES: begin
            if (dp_res_valid) begin
              r_cat   <= dp_res;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
`ifdef CTRL_TIMEOUT_EN
            else if (r_wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
              r_timeout <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_wcnt <= r_wcnt + TW'(1);
            end
`endif
          end
          DONE: r_state <= IDLE;
          default: ;
        endcase
      end
    end
  end

  assign PRDATA        = r_prdata;
  assign rf_we         = r_rf_we;
  assign rf_waddr      = r_rf_waddr;
  assign rf_wdata      = r_rf_wdata;
  assign rf_re         = r_rf_re;
  assign rf_raddr      = r_cnt[AMBA_ADDR_DEPTH-1:0];
  assign dp_valid      = r_dp_valid;
  assign dp_data       = r_dp_data;
  assign dp_last       = r_dp_last;
  assign busy          = w_busy;
  assign CatRecognized = r_cat;
  assign done          = r_done;

endmodule

// File: tb/tb_cat_rec_ctrl.sv
// Scoreboard bench for cat_rec_ctrl: a 4-word instance for runs and a
// default-size instance for address-range writes.
module tb_cat_rec_ctrl;
  localparam int W  = 24;
  localparam int AD = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          psel_s = 0, psel_b = 0, penable = 0, pwrite = 0;
  logic [AD:0]   paddr = '0;
  logic [W-1:0]  pwdata = '0;
  logic          dp_ready = 0, dp_res_valid = 0, dp_res = 0;

  logic [W-1:0]  prdata_s, rf_wdata_s, rf_rdata_s = '0, dp_data_s;
  logic [AD-1:0] rf_waddr_s, rf_raddr_s;
  logic          rf_we_s, rf_re_s, dp_valid_s, dp_last_s;
  logic          busy_s, cat_s, done_s;

  logic [W-1:0]  prdata_b, rf_wdata_b, dp_data_b;
  logic [W-1:0]  rf_rdata_b = '0;
  logic [AD-1:0] rf_waddr_b, rf_raddr_b;
  logic          rf_we_b, rf_re_b, dp_valid_b, dp_last_b;
  logic          busy_b, cat_b, done_b;

  cat_rec_ctrl #(.NUM_WORDS(4), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .rst(rst), .PSEL(psel_s), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_s),
    .rf_we(rf_we_s), .rf_waddr(rf_waddr_s), .rf_wdata(rf_wdata_s),
    .rf_re(rf_re_s), .rf_raddr(rf_raddr_s), .rf_rdata(rf_rdata_s),
    .dp_valid(dp_valid_s), .dp_data(dp_data_s), .dp_last(dp_last_s),
    .dp_ready(dp_ready), .dp_res_valid(dp_res_valid), .dp_res(dp_res),
    .busy(busy_s), .CatRecognized(cat_s), .done(done_s)
  );

  cat_rec_ctrl u_big (
    .clk(clk), .rst(rst), .PSEL(psel_b), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b),
    .rf_we(rf_we_b), .rf_waddr(rf_waddr_b), .rf_wdata(rf_wdata_b),
    .rf_re(rf_re_b), .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
    .dp_valid(dp_valid_b), .dp_data(dp_data_b), .dp_last(dp_last_b),
    .dp_ready(1'b1), .dp_res_valid(1'b0), .dp_res(1'b0),
    .busy(busy_b), .CatRecognized(cat_b), .done(done_b)
  );

  // register file model, 1-cycle read latency
  logic [W-1:0] mem [0:15];
  always @(posedge clk) begin
    if (rf_we_s) mem[rf_waddr_s[3:0]] <= rf_wdata_s;
    if (rf_re_s) rf_rdata_s <= mem[rf_raddr_s[3:0]];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]    q_rd_s[$], q_rd_b[$];
  logic [AD+W-1:0] q_wr_s[$], q_wr_b[$];
  logic [W:0]      q_dp[$];
  logic            rd_s = 0, rd_b = 0;

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s got=event exp=none", name);
  endtask

  always @(posedge clk) begin
    rd_s <= psel_s & penable & ~pwrite;
    rd_b <= psel_b & penable & ~pwrite;
  end

  always @(negedge clk) begin
    if (rd_s) begin
      if (q_rd_s.size() == 0) fail_now("rd_s_unexpected");
      else check("prdata_s", prdata_s, q_rd_s.pop_front());
    end
    if (rd_b) begin
      if (q_rd_b.size() == 0) fail_now("rd_b_unexpected");
      else check("prdata_b", prdata_b, q_rd_b.pop_front());
    end
    if (rf_we_s) begin
      if (q_wr_s.size() == 0) fail_now("rf_we_s_unexpected");
      else check("rf_wr_s", {rf_waddr_s, rf_wdata_s}, q_wr_s.pop_front());
    end
    if (rf_we_b) begin
      if (q_wr_b.size() == 0) fail_now("rf_we_b_unexpected");
      else check("rf_wr_b", {rf_waddr_b, rf_wdata_b}, q_wr_b.pop_front());
    end
    if (dp_valid_s) begin
      if (q_dp.size() == 0) fail_now("dp_valid_unexpected");
      else begin
        check("dp_beat", {dp_data_s, dp_last_s}, q_dp[0]);
        if (dp_ready) void'(q_dp.pop_front());
      end
    end
  end

  task automatic apb_wr(input bit big, input logic [AD:0] a,
                        input logic [W-1:0] d);
    @(posedge clk); #1;
    psel_s = !big; psel_b = big; pwrite = 1; paddr = a; pwdata = d;
    penable = 0;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1;
    psel_s = 0; psel_b = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_rd(input bit big, input logic [AD:0] a,
                        input logic [W-1:0] exp);
    if (big) q_rd_b.push_back(exp);
    else q_rd_s.push_back(exp);
    @(posedge clk); #1;
    psel_s = !big; psel_b = big; pwrite = 0; paddr = a; penable = 0;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1;
    psel_s = 0; psel_b = 0; penable = 0;
  endtask

  task automatic chk_reset(input string name);
    check({name, "_s"}, {prdata_s, rf_we_s, rf_waddr_s, rf_wdata_s,
      rf_re_s, rf_raddr_s, dp_valid_s, dp_data_s, dp_last_s, busy_s,
      cat_s, done_s}, '0);
    check({name, "_b"}, {prdata_b, rf_we_b, rf_waddr_b, rf_wdata_b,
      rf_re_b, rf_raddr_b, dp_valid_b, dp_data_b, dp_last_b, busy_b,
      cat_b, done_b}, '0);
  endtask

  task automatic rst_pulse5();
    @(posedge clk); #2 rst = 1;
    #5 rst = 0;
    @(negedge clk);
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (dp_valid_s) seen = 1;
    end
    if (!seen) fail_now("wait_valid_timeout");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q_dp.size() != 0; i++) @(negedge clk);
    check("drain_left", q_dp.size(), 0);
  endtask

  task automatic pulse_res(input logic v);
    @(posedge clk); #1 dp_res_valid = 1; dp_res = v;
    @(posedge clk); #1 dp_res_valid = 0; dp_res = 0;
  endtask

  task automatic push_image();
    q_dp.push_back({24'h010203, 1'b0});
    q_dp.push_back({24'h040506, 1'b0});
    q_dp.push_back({24'h070809, 1'b0});
    q_dp.push_back({24'h0A0B0C, 1'b1});
  endtask

  logic [W-1:0] img [4];

  initial begin
    img[0] = 24'h010203; img[1] = 24'h040506;
    img[2] = 24'h070809; img[3] = 24'h0A0B0C;

    #10 rst = 0;
    @(negedge clk);
    chk_reset("rst10");

    // result pulse while idle must be ignored
    pulse_res(1'b1);
    apb_rd(0, 0, 24'h00);
    apb_wr(0, 13'd4097, 24'h123456);
    apb_rd(0, 0, 24'h08);
    rst_pulse5();
    chk_reset("rst5a");
    apb_rd(0, 0, 24'h00);

    q_wr_b.push_back({12'd5, 24'h0000AB});
    apb_wr(1, 13'd5, 24'h0000AB);
    apb_wr(1, 13'd4097, 24'h00FFFF);
    apb_rd(1, 0, 24'h08);
    apb_rd(1, 13'd5, 24'h00);
    rst_pulse5();
    chk_reset("rst5b");

    for (int i = 0; i < 4; i++) begin
      q_wr_s.push_back({AD'(i + 1), img[i]});
      apb_wr(0, 13'(i + 1), img[i]);
    end

    // run 1: free-flowing, busy write dropped, cat found
    dp_ready = 1;
    push_image();
    apb_wr(0, 0, 24'h1);
    apb_wr(0, 13'd2, 24'hFFFFFF);
    wait_drain();
    pulse_res(1'b1);
    @(negedge clk);
    check("done_run1", done_s, 1'b1);
    check("cat_run1", cat_s, 1'b1);
    apb_rd(0, 0, 24'h0E);

    // run 2: stall on word 2, no cat
    dp_ready = 0;
    push_image();
    apb_wr(0, 0, 24'h1);
    for (int b = 0; b < 4; b++) begin
      wait_valid();
      if (b == 1) repeat (7) @(posedge clk);
      @(posedge clk); #1 dp_ready = 1;
      @(posedge clk); #1 dp_ready = 0;
    end
    check("drain_run2", q_dp.size(), 0);
    pulse_res(1'b0);
    apb_rd(0, 0, 24'h02);

    // run 3: abort mid-stream, then rerun
    q_dp.push_back({24'h010203, 1'b0});
    apb_wr(0, 0, 24'h1);
    wait_valid();
    apb_wr(0, 0, 24'h0);
    q_dp.delete();
    @(negedge clk);
    check("abort_busy", busy_s, 1'b0);
    check("abort_done", done_s, 1'b0);
    check("abort_valid", dp_valid_s, 1'b0);
    apb_rd(0, 0, 24'h00);
    dp_ready = 1;
    push_image();
    apb_wr(0, 0, 24'h1);
    wait_drain();
    repeat (100) @(posedge clk);
`ifdef CTRL_TIMEOUT_EN
    apb_rd(0, 0, 24'h10);
`else
    apb_rd(0, 0, 24'h01);
`endif
    repeat (2) @(negedge clk);

    check("q_rd_s_left", q_rd_s.size(), 0);
    check("q_rd_b_left", q_rd_b.size(), 0);
    check("q_wr_s_left", q_wr_s.size(), 0);
    check("q_wr_b_left", q_wr_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
